bp_cfg_bus_sequencer: RTL and testbench

//  Boot-time configuration master for the cfg bus. On start_i it freezes all cores,

---
 rtl/bp_cfg_bus_sequencer.sv | 96 +++++++++
 tb/tb_bp_cfg_bus_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_bus_sequencer.sv
// Boot-time cfg bus master: freezes all cores, writes every valid cfg table entry
// to every core (core-major), then releases freeze and reports done.
module bp_cfg_bus_sequencer #(
  parameter int num_core_p       = 1,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int num_entries_p    = 8,
  localparam int idx_width_lp    = (num_entries_p > 1) ? $clog2(num_entries_p) : 1,
  localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic [idx_width_lp-1:0]     entry_idx_o,
  input  logic                        entry_v_i,
  input  logic [cfg_addr_width_p-1:0] entry_addr_i,
  input  logic [cfg_data_width_p-1:0] entry_data_i,
  output logic                        cfg_v_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        freeze_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [1:0]                  state_o
);

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_freeze = 2'd1;
  localparam logic [1:0] st_send   = 2'd2;
  localparam logic [1:0] st_done   = 2'd3;

  localparam logic [idx_width_lp-1:0]  last_idx_lp  = idx_width_lp'(num_entries_p - 1);
  localparam logic [core_width_lp-1:0] last_core_lp = core_width_lp'(num_core_p - 1);

  logic [1:0]               state_r;
  logic [idx_width_lp-1:0]  idx_r;
  logic [core_width_lp-1:0] core_r;
  logic                     in_send;
  logic                     advance;

  // Handshake: a write transfers on a rising edge where cfg_v_o && cfg_ready_i;
  // while cfg_v_o is high, core/addr/data stay stable until that transfer.
  // cfg_ready_i without cfg_v_o is ignored.
  assign in_send = (state_r == st_send);
  // Invalid entries are skipped after a single bubble cycle.
  assign advance = in_send && (entry_v_i ? cfg_ready_i : 1'b1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= st_idle;
      idx_r   <= '0;
      core_r  <= '0;
    end else begin
      case (state_r)
        st_idle, st_done: begin
          if (start_i) begin
            state_r <= st_freeze;
            idx_r   <= '0;
            core_r  <= '0;
          end
        end
        st_freeze: state_r <= st_send;
        st_send: begin
          if (advance) begin
            if (idx_r == last_idx_lp) begin
              idx_r <= '0;
              if (core_r == last_core_lp) begin
                core_r  <= '0;
                state_r <= st_done;
              end else begin
                core_r <= core_r + 1'b1;
              end
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
        end
        default: state_r <= st_idle;
      endcase
    end
  end

  assign entry_idx_o = idx_r;
  assign cfg_v_o     = in_send && entry_v_i;
  assign cfg_core_o  = cfg_core_width_p'(core_r);
  assign cfg_addr_o  = entry_addr_i;
  assign cfg_data_o  = entry_data_i;
  assign freeze_o    = (state_r == st_freeze) || in_send;
  assign busy_o      = freeze_o;
  assign done_o      = (state_r == st_done);
  assign state_o     = state_r;

endmodule

// File: tb/tb_bp_cfg_bus_sequencer.sv
// Directed bench for bp_cfg_bus_sequencer: a 2-core/3-entry instance for the main
// scenarios and a 1-core/1-entry instance for the degenerate boundary.
module tb_bp_cfg_bus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: N=2, E=3
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [2:0]  valid_mask = 3'b111;
  logic [1:0]  idx;
  logic        entry_v;
  logic [15:0] entry_addr;
  logic [63:0] entry_data;
  logic        cfg_v;
  logic [7:0]  cfg_core;
  logic [15:0] cfg_addr;
  logic [63:0] cfg_data;
  logic        freeze, busy, done;
  logic [1:0]  state;

  function automatic logic [15:0] tbl_addr(input logic [7:0] i);
    return 16'h1000 + 16'(i);
  endfunction

  function automatic logic [63:0] tbl_data(input logic [7:0] i);
    return 64'hC0FF_EE00_0000_0000 + 64'(i) * 64'd3 + 64'd1;
  endfunction

  assign entry_v    = (idx < 2'd3) ? valid_mask[idx] : 1'b0;
  assign entry_addr = tbl_addr(8'(idx));
  assign entry_data = tbl_data(8'(idx));

  bp_cfg_bus_sequencer #(
    .num_core_p(2), .cfg_core_width_p(8), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .num_entries_p(3)
  ) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .entry_idx_o(idx),
    .entry_v_i(entry_v), .entry_addr_i(entry_addr), .entry_data_i(entry_data),
    .cfg_v_o(cfg_v), .cfg_core_o(cfg_core), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
    .cfg_ready_i(ready), .freeze_o(freeze), .busy_o(busy), .done_o(done), .state_o(state)
  );

  // Boundary instance: N=1, E=1
  logic        start1 = 1'b0;
  logic        ready1 = 1'b1;
  logic [0:0]  idx1;
  logic        cfg_v1;
  logic [7:0]  cfg_core1;
  logic [15:0] cfg_addr1;
  logic [63:0] cfg_data1;
  logic        freeze1, busy1, done1;
  logic [1:0]  state1;

  bp_cfg_bus_sequencer #(
    .num_core_p(1), .cfg_core_width_p(8), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .num_entries_p(1)
  ) dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start1), .entry_idx_o(idx1),
    .entry_v_i(1'b1), .entry_addr_i(16'h0042), .entry_data_i(64'h1122_3344_5566_7788),
    .cfg_v_o(cfg_v1), .cfg_core_o(cfg_core1), .cfg_addr_o(cfg_addr1), .cfg_data_o(cfg_data1),
    .cfg_ready_i(ready1), .freeze_o(freeze1), .busy_o(busy1), .done_o(done1), .state_o(state1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every accepted write must match the head of exp_q as {core, idx}.
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (cfg_v && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {cfg_core, 6'd0, idx}, 64'hFFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("write_core_idx", {cfg_core, 6'd0, idx}, e);
        check("write_addr", cfg_addr, tbl_addr(8'(e[7:0])));
        check("write_data", cfg_data, tbl_data(8'(e[7:0])));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [2:0] mask);
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 3; i++)
        if (mask[i]) exp_q.push_back({8'(c), 8'(i)});
  endtask

  // Pulse start for the edge that ends cycle 0; returns inside cycle 1.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_done);
    check({tag, "_cfg_v"}, cfg_v, 1'b0);
    check({tag, "_freeze"}, freeze, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, exp_done);
  endtask

  task automatic check_write(input string tag, input int c, input int i);
    check({tag, "_v"}, cfg_v, 1'b1);
    check({tag, "_core"}, cfg_core, 64'(c));
    check({tag, "_idx"}, idx, 64'(i));
    check({tag, "_addr"}, cfg_addr, tbl_addr(8'(i)));
    check({tag, "_data"}, cfg_data, tbl_data(8'(i)));
    check({tag, "_freeze"}, freeze, 1'b1);
  endtask

  initial begin
    #2;
    check_idle_outputs("reset", 1'b0);
    check("reset_idx", idx, 0);
    check("reset_state", state, 0);
    check("reset1_done", done1, 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    check_idle_outputs("idle", 1'b0);

    // 1: all valid, ready=1 -> writes in cycles 2..7, done from cycle 8
    push_all(3'b111);
    kick();
    check("t1_freeze_c1", freeze, 1'b1);
    check("t1_busy_c1", busy, 1'b1);
    check("t1_v_c1", cfg_v, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_write("t1_wr", k / 3, k % 3);
    end
    step();
    check_idle_outputs("t1_c8", 1'b1);
    step();
    check("t1_done_sticky", done, 1'b1);

    // 2: stall c0/i1 for 4 cycles -> completion moves from cycle 8 to 12
    push_all(3'b111);
    kick();
    check("t2_done_cleared", done, 1'b0);
    check("t2_freeze_c1", freeze, 1'b1);
    step();
    check_write("t2_c0i0", 0, 0);
    step();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_write("t2_stall", 0, 1);
      step();
    end
    ready = 1'b1;
    check_write("t2_c7", 0, 1);
    repeat (4) step();
    check("t2_c11_not_done", done, 1'b0);
    check_write("t2_c11", 1, 2);
    step();
    check_idle_outputs("t2_c12", 1'b1);

    // 3: entry 1 invalid -> bubbles at idx 1, done still at cycle 8
    valid_mask = 3'b101;
    push_all(3'b101);
    kick();
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_v", cfg_v, (k % 3) != 1);
      check("t3_idx", idx, 64'(k % 3));
      check("t3_core", cfg_core, 64'(k / 3));
      check("t3_busy", busy, 1'b1);
    end
    step();
    check_idle_outputs("t3_c8", 1'b1);
    valid_mask = 3'b111;

    // 4: start during SEND ignored; start in DONE restarts the sequence
    push_all(3'b111);
    push_all(3'b111);
    kick();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_write("t4_no_restart", 0, 2);
    repeat (4) step();
    check_idle_outputs("t4_c8", 1'b1);
    kick();
    check("t4_restart_done", done, 1'b0);
    check("t4_restart_freeze", freeze, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      check_write("t4_wr", k / 3, k % 3);
    end
    step();
    check_idle_outputs("t4_end", 1'b1);

    // 5: async reset mid-SEND; only c0/i0 completes before it
    exp_q.push_back({8'd0, 8'd0});
    kick();
    step();
    step();
    check_write("t5_pre_rst", 0, 1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t5_async", 1'b0);
    check("t5_idx", idx, 0);
    check("t5_state", state, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check_idle_outputs("t5_idle", 1'b0);
    check("t5_idle_state", state, 0);
    push_all(3'b111);
    kick();
    step();
    check_write("t5_restart", 0, 0);
    repeat (5) step();
    step();
    check_idle_outputs("t5_end", 1'b1);

    // 6: N=1,E=1 -> single write in cycle 2, done in cycle 3, twice
    for (int r = 0; r < 2; r++) begin
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check("t6_freeze", freeze1, 1'b1);
      check("t6_v_c1", cfg_v1, 1'b0);
      step();
      check("t6_v", cfg_v1, 1'b1);
      check("t6_core", cfg_core1, 0);
      check("t6_idx", idx1, 0);
      check("t6_addr", cfg_addr1, 16'h0042);
      check("t6_data", cfg_data1, 64'h1122_3344_5566_7788);
      step();
      check("t6_done", done1, 1'b1);
      check("t6_freeze_off", freeze1, 1'b0);
      check("t6_busy_off", busy1, 1'b0);
      check("t6_v_off", cfg_v1, 1'b0);
      check("t6_idx_wrap", idx1, 0);
    end

    step();
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
